// File: rtl/img_xform_responder.sv
// img_xform_responder
//   Responder behind the image-transform test interface. It holds a DEPTH-word image buffer,
//   with DW/PIX_W pixels packed into each word. It serves WRITE/READ, and it runs whole-buffer
//   transforms (INVERT, MIRROR, CLEAR) at one word per cycle. When a transform finishes it raises
//   done_int, which stays high until the bench returns int_ack.
//
//   Optional feature: define IMG_XFORM_STATUS_EN to add a saturating drop counter and a STATUS
//   opcode (6).
//
//   Ports
//     clk       in   1    clock; all logic on posedge
//     rst       in   1    synchronous active-high reset; buffer contents are retained
//     addr      in   AW   word address for WRITE/READ
//     wdata     in   DW   write data
//     op        in   4    command, sampled every cycle
//     int_ack   in   1    acknowledges done_int
//     rdata     out  DW   registered read data
//     done_int  out  1    registered level interrupt: transform complete
module img_xform_responder #(
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 32,
  parameter int unsigned PIX_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [3:0]    op,
  input  logic          int_ack,
  output logic [DW-1:0] rdata,
  output logic          done_int
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned NPIX  = DW / PIX_W;

  localparam logic [3:0] OpWrite  = 4'd1;
  localparam logic [3:0] OpRead   = 4'd2;
  localparam logic [3:0] OpInvert = 4'd3;
  localparam logic [3:0] OpMirror = 4'd4;
  localparam logic [3:0] OpClear  = 4'd5;
`ifdef IMG_XFORM_STATUS_EN
  localparam logic [3:0] OpStatus = 4'd6;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [1:0] {XfInvert, XfMirror, XfClear} xf_e;

  state_e        state_q, state_d;
  xf_e           xf_q, xf_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          done_d;
  logic [DW-1:0] rdata_d;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  function automatic logic [DW-1:0] mirror_word(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NPIX; i++) begin
      r[i*PIX_W +: PIX_W] = w[(NPIX-1-i)*PIX_W +: PIX_W];
    end
    return r;
  endfunction

  // Inverting every pixel, (2**PIX_W-1)-p, is the same as a bitwise NOT of the whole word.
  function automatic logic [DW-1:0] xform(input xf_e kind, input logic [DW-1:0] w);
    logic [DW-1:0] r;
    case (kind)
      XfInvert: r = ~w;
      XfMirror: r = mirror_word(w);
      default:  r = '0;
    endcase
    return r;
  endfunction

`ifdef IMG_XFORM_STATUS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       drop;
  logic       is_start;

  assign is_start = (op == OpInvert) || (op == OpMirror) || (op == OpClear);
  // STATUS is accepted even in RUN, so it never counts as a drop.
  assign drop = ((state_q == StRun) && (is_start || op == OpWrite || op == OpRead)) ||
                ((state_q == StDone) && is_start);
  assign drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
`endif

  always_comb begin
    state_d   = state_q;
    xf_d      = xf_q;
    ptr_d     = ptr_q;
    done_d    = done_int;
    rdata_d   = rdata;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    unique case (state_q)
      StIdle: begin
        case (op)
          OpWrite:  mem_we = 1'b1;
          OpRead:   rdata_d = mem[addr];
          OpInvert: begin xf_d = XfInvert; ptr_d = '0; state_d = StRun; end
          OpMirror: begin xf_d = XfMirror; ptr_d = '0; state_d = StRun; end
          OpClear:  begin xf_d = XfClear;  ptr_d = '0; state_d = StRun; end
          default: ;
        endcase
      end
      StRun: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = xform(xf_q, mem[ptr_q]);
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == {AW{1'b1}}) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        // START ops are dropped here simply by not being decoded.
        case (op)
          OpWrite: mem_we = 1'b1;
          OpRead:  rdata_d = mem[addr];
          default: ;
        endcase
        if (int_ack) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef IMG_XFORM_STATUS_EN
    if (op == OpStatus) begin
      rdata_d = '0;
      rdata_d[DW-1] = (state_q == StRun);
      rdata_d[DW-2] = done_int;
      rdata_d[7:0]  = drop_cnt_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      xf_q     <= XfInvert;
      ptr_q    <= '0;
      done_int <= 1'b0;
      rdata    <= '0;
`ifdef IMG_XFORM_STATUS_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      xf_q     <= xf_d;
      ptr_q    <= ptr_d;
      done_int <= done_d;
      rdata    <= rdata_d;
`ifdef IMG_XFORM_STATUS_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // Buffer is never reset, and a reset edge must not commit a write or a transform step.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_img_xform_responder.sv
// Directed self-checking bench for img_xform_responder at default parameters (DEPTH = 64).
module tb_img_xform_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  op;
  logic        int_ack;
  logic [31:0] rdata;
  logic        done_int;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] NOP = 4'd0, WR = 4'd1, RD = 4'd2, INV = 4'd3, MIR = 4'd4, CLR = 4'd5;

  img_xform_responder dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .op       (op),
    .int_ack  (int_ack),
    .rdata    (rdata),
    .done_int (done_int)
  );

  always #5 clk = ~clk;

  // Inputs are applied 1 time unit after a posedge; the call then spans exactly one edge.
  task automatic step(input logic [3:0] o, input logic [5:0] a, input logic [31:0] d);
    op = o;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    op = NOP;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(NOP, 6'd0, 32'd0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    addr = '0;
    wdata = '0;
    op = NOP;
    int_ack = 1'b0;
    @(posedge clk);
    #1;
    idle(1);
    rst = 1'b0;
    check("reset_rdata", rdata, 32'h0);
    check("reset_done", {31'd0, done_int}, 32'h0);

    // Plain write/read with 1-cycle latency; rdata holds afterwards.
    step(WR, 6'd5, 32'h1234_5678);
    step(RD, 6'd5, 32'd0);
    check("read_a5", rdata, 32'h1234_5678);
    idle(2);
    check("rdata_hold", rdata, 32'h1234_5678);

    // INVERT: START at edge N -> done_int after edge N+64.
    step(WR, 6'd0, 32'h00FF_1080);
    int_ack = 1'b1;   // ack in IDLE is ignored
    step(INV, 6'd0, 32'd0);
    int_ack = 1'b0;
    idle(63);
    check("inv_done_early", {31'd0, done_int}, 32'h0);
    idle(1);
    check("inv_done", {31'd0, done_int}, 32'h1);
    step(RD, 6'd0, 32'd0);
    check("inv_read_in_done", rdata, 32'hFF00_EF7F);
    check("inv_done_held", {31'd0, done_int}, 32'h1);
    int_ack = 1'b1;
    step(NOP, 6'd0, 32'd0);
    int_ack = 1'b0;
    check("inv_ack", {31'd0, done_int}, 32'h0);
    step(RD, 6'd5, 32'd0);
    check("inv_a5", rdata, 32'hEDCB_A987);

    // MIRROR; int_ack during RUN must be ignored.
    step(WR, 6'd63, 32'hAABB_CCDD);
    step(MIR, 6'd0, 32'd0);
    int_ack = 1'b1;
    idle(5);
    int_ack = 1'b0;
    idle(58);
    check("mir_done_early", {31'd0, done_int}, 32'h0);
    idle(1);
    check("mir_done", {31'd0, done_int}, 32'h1);
    int_ack = 1'b1;
    step(NOP, 6'd0, 32'd0);
    int_ack = 1'b0;
    check("mir_ack", {31'd0, done_int}, 32'h0);
    step(RD, 6'd63, 32'd0);
    check("mir_a63", rdata, 32'hDDCC_BBAA);
    step(RD, 6'd0, 32'd0);
    check("mir_a0", rdata, 32'h7FEF_00FF);

    // CLEAR; WRITE and READ at cycles 10/11 of RUN are dropped.
    step(WR, 6'd1, 32'h5555_AAAA);
    step(CLR, 6'd0, 32'd0);
    idle(9);
    step(WR, 6'd1, 32'hDEAD_BEEF);
    step(RD, 6'd1, 32'd0);
    check("run_read_dropped", rdata, 32'h7FEF_00FF);
    idle(52);
    check("clr_done_early", {31'd0, done_int}, 32'h0);
    idle(1);
    check("clr_done", {31'd0, done_int}, 32'h1);
    int_ack = 1'b1;
    step(NOP, 6'd0, 32'd0);
    int_ack = 1'b0;
    step(RD, 6'd1, 32'd0);
    check("clr_a1", rdata, 32'h0);
    step(RD, 6'd63, 32'd0);
    check("clr_a63", rdata, 32'h0);
`ifdef IMG_XFORM_STATUS_EN
    step(4'd6, 6'd0, 32'd0);
    check("status_drops", rdata, 32'h0000_0002);
`endif

    // Reset at cycle 20 of an INVERT run: words 0..18 inverted, rest untouched.
    step(WR, 6'd0, 32'h0102_0304);
    step(WR, 6'd40, 32'h1111_2222);
    step(INV, 6'd0, 32'd0);
    idle(19);
    rst = 1'b1;
    step(NOP, 6'd0, 32'd0);
    rst = 1'b0;
    check("rst_done", {31'd0, done_int}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    idle(70);
    check("rst_no_finish", {31'd0, done_int}, 32'h0);
    step(RD, 6'd0, 32'd0);
    check("rst_a0", rdata, 32'hFEFD_FCFB);
    step(RD, 6'd18, 32'd0);
    check("rst_a18", rdata, 32'hFFFF_FFFF);
    step(RD, 6'd19, 32'd0);
    check("rst_a19", rdata, 32'h0);
    step(RD, 6'd40, 32'd0);
    check("rst_a40", rdata, 32'h1111_2222);
    step(WR, 6'd2, 32'hCAFE_F00D);
    step(RD, 6'd2, 32'd0);
    check("idle_wr_rd", rdata, 32'hCAFE_F00D);

    // In DONE, int_ack and START together: ack wins, no new run.
    step(INV, 6'd0, 32'd0);
    idle(64);
    check("ack_start_done", {31'd0, done_int}, 32'h1);
    int_ack = 1'b1;
    step(INV, 6'd0, 32'd0);
    int_ack = 1'b0;
    check("ack_start_clear", {31'd0, done_int}, 32'h0);
    idle(70);
    check("ack_start_no_run", {31'd0, done_int}, 32'h0);
    step(RD, 6'd0, 32'd0);
    check("ack_start_a0", rdata, 32'h0102_0304);
    step(RD, 6'd40, 32'd0);
    check("ack_start_a40", rdata, 32'hEEEE_DDDD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
